pc_redirect_if: RTL

Fetch-stage PC register and redirect controller at the IF end of the branch-target path. It consumes the EX-stage branch/JALR target, already registered by the EX pipeline register, and the ID-stage JAL target, and selects the next fetch PC. It issues the same-cycle flushD/flushE squash strobes and holds a redirect that arrives while fetch is stalled until fetch resumes.

---
 rtl/rv32_pipe_pkg.sv | 18 +
 rtl/pc_next_sel.sv | 49 ++++
 rtl/pc_redirect_if.sv | 78 +++++++
 3 files changed

// File: rtl/rv32_pipe_pkg.sv
// Shared pipeline constants and types for the RV32 fetch/redirect path.
package rv32_pipe_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        PEND_IDLE = 1'b0,
        PEND_WAIT = 1'b1
    } pend_state_e;

    // Fetch targets are word-aligned; low bits are simply dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux with squash strobes for the fetch stage.
module pc_next_sel
    import rv32_pipe_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            pend,
    input  logic [XLEN-1:0] pend_target,
    input  logic            br_taken_EX,
    input  logic [XLEN-1:0] br_target_EX,
    input  logic            jalr_EX,
    input  logic [XLEN-1:0] jalr_target_EX,
    input  logic            jal_ID,
    input  logic [XLEN-1:0] jal_target_ID,
    output logic [XLEN-1:0] next_pc,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_target,
    output logic            flushD,
    output logic            flushE
);

    logic            ex_redir;
    logic            jal_ok;
    logic [XLEN-1:0] ex_target;
    logic [XLEN-1:0] jal_target;

    assign ex_redir   = br_taken_EX | jalr_EX;
    assign ex_target  = align_pc(br_taken_EX ? br_target_EX : jalr_target_EX);
    assign jal_target = align_pc(jal_target_ID);
    // JAL only acts when no older redirect is in flight.
    assign jal_ok     = jal_ID & ~ex_redir & ~pend;

    assign redirect_valid  = ex_redir | jal_ok;
    assign redirect_target = ex_redir ? ex_target : jal_target;
    assign flushD          = ex_redir | jal_ok;
    assign flushE          = ex_redir;

    // A fresh EX redirect supersedes any older pending target.
    always_comb begin
        next_pc = pc + XLEN'(PC_STEP);
        if (ex_redir) begin
            next_pc = ex_target;
        end else if (pend) begin
            next_pc = pend_target;
        end else if (jal_ok) begin
            next_pc = jal_target;
        end
    end

endmodule

// File: rtl/pc_redirect_if.sv
// Fetch PC register and stall-tolerant redirect holder.
module pc_redirect_if
    import rv32_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bubbleF,
    input  logic            br_taken_EX,
    input  logic [XLEN-1:0] br_target_EX,
    input  logic            jalr_EX,
    input  logic [XLEN-1:0] jalr_target_EX,
    input  logic            jal_ID,
    input  logic [XLEN-1:0] jal_target_ID,
    output logic [XLEN-1:0] pc_IF,
    output logic            flushD,
    output logic            flushE,
    output logic            redirect_pending
);

    pend_state_e     state_q, state_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] sel_next_pc;
    logic            sel_redirect_valid;
    logic [XLEN-1:0] sel_redirect_target;
    logic            sel_flushD;
    logic            sel_flushE;

    pc_next_sel u_sel (
        .pc              (pc_IF),
        .pend            (state_q == PEND_WAIT),
        .pend_target     (pend_tgt_q),
        .br_taken_EX     (br_taken_EX),
        .br_target_EX    (br_target_EX),
        .jalr_EX         (jalr_EX),
        .jalr_target_EX  (jalr_target_EX),
        .jal_ID          (jal_ID),
        .jal_target_ID   (jal_target_ID),
        .next_pc         (sel_next_pc),
        .redirect_valid  (sel_redirect_valid),
        .redirect_target (sel_redirect_target),
        .flushD          (sel_flushD),
        .flushE          (sel_flushE)
    );

    assign flushD           = sel_flushD & ~rst;
    assign flushE           = sel_flushE & ~rst;
    assign redirect_pending = (state_q == PEND_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PEND_IDLE;
            pend_tgt_q <= '0;
            pc_IF      <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pend_tgt_q <= pend_tgt_d;
            pc_IF      <= pc_d;
        end
    end

    // While stalled, any accepted redirect is parked; once fetch runs, the mux decides.
    always_comb begin
        state_d    = state_q;
        pend_tgt_d = pend_tgt_q;
        pc_d       = pc_IF;
        if (!bubbleF) begin
            pc_d    = sel_next_pc;
            state_d = PEND_IDLE;
        end else if (sel_redirect_valid) begin
            pend_tgt_d = sel_redirect_target;
            state_d    = PEND_WAIT;
        end
    end

endmodule
